// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall scheduler.
// Imported by the MDU busy sequencer and the stall controller top.
package pipe_stall_ctrl_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  localparam logic [1:0] TUSE_NEVER = 2'd3;
  localparam logic [1:0] TNEW_NOW   = 2'd0;
  localparam logic [1:0] TNEW_ONE   = 2'd1;
  localparam logic [1:0] TNEW_TWO   = 2'd2;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Source read in D collides with a younger-than-needed result downstream.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (src == a3) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mdu_busy_seq.sv
// MDU busy sequencer: loads a cycle count on an idle start, then
// counts down; busy while the count is nonzero.
module mdu_busy_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  mdu_state_e       state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    state   = (cnt != '0) ? MDU_BUSY : MDU_IDLE;
    unique case (state)
      MDU_IDLE: begin
        if (start) begin
          cnt_nxt = is_div ? CNT_W'(DIV_CYCLES)
                           : CNT_W'(MULT_CYCLES);
        end
      end
      // A start while busy cannot reload; it is simply dropped.
      MDU_BUSY: cnt_nxt = cnt - CNT_W'(1);
      default:  cnt_nxt = '0;
    endcase
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall scheduler: drives PC and F/D enables, D/E bubble,
// owns the MDU busy sequencer and a saturating stall counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_use_D,
  input  logic [4:0]  a3_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  a3_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_div_E,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  mdu_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mdu_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_E),
    .is_div (md_div_E),
    .busy   (mdu_busy)
  );

  always_comb begin
    stall_rs = raw_hazard(rs_D, tuse_rs_D, a3_E, tnew_E)
             | raw_hazard(rs_D, tuse_rs_D, a3_M, tnew_M);
    stall_rt = raw_hazard(rt_D, tuse_rt_D, a3_E, tnew_E)
             | raw_hazard(rt_D, tuse_rt_D, a3_M, tnew_M);
    stall_md = md_use_D & (mdu_busy | md_start_E);
  end

  // Reset forces the pipe to advance regardless of hazards.
  assign stall = ~reset & (stall_rs | stall_rt | stall_md);
  assign pc_en = ~stall;
  assign d_en  = ~stall;
  assign e_clr = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a cycle-indexed reference
// model compared every cycle plus hand-computed literal expectations.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, a3_E, a3_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_use_D, md_start_E, md_div_E;
  logic        pc_en, d_en, e_clr, mdu_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rs_D         (rs_D),
    .rt_D         (rt_D),
    .tuse_rs_D    (tuse_rs_D),
    .tuse_rt_D    (tuse_rt_D),
    .md_use_D     (md_use_D),
    .a3_E         (a3_E),
    .tnew_E       (tnew_E),
    .a3_M         (a3_M),
    .tnew_M       (tnew_M),
    .md_start_E   (md_start_E),
    .md_div_E     (md_div_E),
    .pc_en        (pc_en),
    .d_en         (d_en),
    .e_clr        (e_clr),
    .mdu_busy     (mdu_busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: MDU busy is the window of cycles after the
  // accepted start; stall count is a plain saturating tally.
  int          cyc = 0;
  int          md_start_cyc = -1000;
  int          md_len = 0;
  int unsigned m_stalls = 0;
  bit          chk_en = 1'b0;

  function automatic bit m_busy();
    return (cyc > md_start_cyc) && (cyc <= md_start_cyc + md_len);
  endfunction

  function automatic bit hz(input logic [4:0] s, input logic [1:0] tu,
                            input logic [4:0] d, input logic [1:0] tn);
    if (s == 5'd0) return 1'b0;
    if (s != d) return 1'b0;
    return int'(tu) < int'(tn);
  endfunction

  function automatic bit m_stall();
    bit data_st, md_st;
    if (reset) return 1'b0;
    data_st = hz(rs_D, tuse_rs_D, a3_E, tnew_E)
           || hz(rs_D, tuse_rs_D, a3_M, tnew_M)
           || hz(rt_D, tuse_rt_D, a3_E, tnew_E)
           || hz(rt_D, tuse_rt_D, a3_M, tnew_M);
    md_st = md_use_D && (m_busy() || md_start_E);
    return data_st || md_st;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      md_start_cyc = -1000;
      m_stalls     = 0;
    end else begin
      if (md_start_E && !m_busy()) begin
        md_start_cyc = cyc;
        md_len       = md_div_E ? 10 : 5;
      end
      if (m_stall() && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit st;
      st = m_stall();
      checks++;
      if (pc_en !== !st || d_en !== !st || e_clr !== st) begin
        errors++;
        $display("FAIL model_enables cyc=%0d got pc_en=%b d_en=%b e_clr=%b want stall=%b",
                 cyc, pc_en, d_en, e_clr, st);
      end
      checks++;
      if (mdu_busy !== m_busy()) begin
        errors++;
        $display("FAIL model_busy cyc=%0d got %b want %b", cyc, mdu_busy, m_busy());
      end
      checks++;
      if (stall_cycles !== m_stalls) begin
        errors++;
        $display("FAIL model_stall_cycles cyc=%0d got %0d want %0d",
                 cyc, stall_cycles, m_stalls);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rs_D = 0; rt_D = 0; a3_E = 0; a3_M = 0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 0; tnew_M = 0;
    md_use_D = 0; md_start_E = 0; md_div_E = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    // Load-use hazard held during reset must not stall
    a3_E = 5; tnew_E = 2; rs_D = 5; tuse_rs_D = 1;
    nxt();
    chk_en = 1'b1;
    @(negedge clk);
    lit("rst_pc_en", 32'(pc_en), 1);
    lit("rst_e_clr", 32'(e_clr), 0);
    nxt();
    @(negedge clk);
    lit("rst_busy", 32'(mdu_busy), 0);
    lit("rst_stall_cycles", stall_cycles, 0);

    // Load-use on rs through E
    nxt();
    reset = 1'b0;
    @(negedge clk);
    lit("lu_pc_en", 32'(pc_en), 0);
    lit("lu_e_clr", 32'(e_clr), 1);
    lit("lu_d_en", 32'(d_en), 0);
    nxt();
    a3_E = 0; a3_M = 5; tnew_M = 1;
    @(negedge clk);
    lit("lu_release_pc_en", 32'(pc_en), 1);
    lit("lu_stall_cycles", stall_cycles, 1);

    // rt hazard through M
    nxt();
    clr_in();
    rt_D = 7; tuse_rt_D = 0; a3_M = 7; tnew_M = 1;
    @(negedge clk);
    lit("rt_m_pc_en", 32'(pc_en), 0);

    // $0 never stalls
    nxt();
    clr_in();
    a3_E = 0; tnew_E = 2; rs_D = 0; tuse_rs_D = 0;
    @(negedge clk);
    lit("zero_pc_en", 32'(pc_en), 1);
    lit("zero_stall_cycles", stall_cycles, 2);

    // Mult then mflo held in D
    nxt();
    clr_in();
    md_start_E = 1; md_use_D = 1;
    @(negedge clk);
    lit("mult_t_pc_en", 32'(pc_en), 0);
    lit("mult_t_busy", 32'(mdu_busy), 0);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      md_start_E = 0;
      @(negedge clk);
      lit($sformatf("mult_busy_%0d", i), 32'(mdu_busy), 1);
      lit($sformatf("mult_pc_en_%0d", i), 32'(pc_en), 0);
    end
    nxt();
    @(negedge clk);
    lit("mult_done_busy", 32'(mdu_busy), 0);
    lit("mult_done_pc_en", 32'(pc_en), 1);
    lit("mult_stall_cycles", stall_cycles, 8);

    // Div with an unrelated instruction in D
    nxt();
    clr_in();
    md_start_E = 1; md_div_E = 1;
    @(negedge clk);
    lit("div_t_pc_en", 32'(pc_en), 1);
    for (int i = 1; i <= 10; i++) begin
      nxt();
      md_start_E = 0;
      @(negedge clk);
      lit($sformatf("div_busy_%0d", i), 32'(mdu_busy), 1);
      lit($sformatf("div_pc_en_%0d", i), 32'(pc_en), 1);
    end
    nxt();
    @(negedge clk);
    lit("div_done_busy", 32'(mdu_busy), 0);

    // Reset at busy cycle 4 of a div aborts it
    nxt();
    md_start_E = 1; md_div_E = 1;
    for (int i = 1; i <= 4; i++) begin
      nxt();
      md_start_E = 0;
    end
    reset = 1'b1; md_use_D = 1;
    @(negedge clk);
    lit("rdiv_busy_before", 32'(mdu_busy), 1);
    lit("rdiv_pc_en_in_reset", 32'(pc_en), 1);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    lit("rdiv_busy_after", 32'(mdu_busy), 0);
    lit("rdiv_stall_cycles", stall_cycles, 0);
    lit("rdiv_pc_en", 32'(pc_en), 1);

    // Illegal restarts at busy cycles 3 and 5 of a mult are dropped
    nxt();
    clr_in();
    md_start_E = 1;
    for (int i = 1; i <= 5; i++) begin
      nxt();
      md_start_E = (i == 3 || i == 5);
      md_div_E = md_start_E;
      @(negedge clk);
      lit($sformatf("rst_mult_busy_%0d", i), 32'(mdu_busy), 1);
    end
    nxt();
    clr_in();
    @(negedge clk);
    lit("restart_done_busy", 32'(mdu_busy), 0);
    nxt();
    @(negedge clk);
    lit("restart_idle_busy", 32'(mdu_busy), 0);

    nxt();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
